// File: rtl/stream_pack_pkg.sv
// stream_pack_pkg
//   Shared helpers for the stream packer: derived widths from the top-level
//   parameters, beat-counter width, and the partial-group valid mask used
//   when a pack is flushed early (STREAM_PACK_FLUSH_EN builds only).
package stream_pack_pkg;

  localparam int MAX_GROUPS = 64;

  function automatic int num_beats(int band_w, int data_w, int be_par);
    return (2 * data_w * be_par) / band_w;
  endfunction

  function automatic int groups(int be_par, int par_per_ctl);
    return be_par / par_per_ctl;
  endfunction

  function automatic int grp_w(int data_w, int par_per_ctl);
    return 2 * data_w * par_per_ctl;
  endfunction

  function automatic int cnt_w(int n_beats);
    return $clog2(n_beats) + 1;
  endfunction

  // Sets one bit per group touched by the first filled_bits of the word,
  // i.e. the low ceil(filled_bits/grp_bits) bits.
  function automatic logic [MAX_GROUPS-1:0] partial_mask(int filled_bits, int grp_bits);
    int n;
    logic [MAX_GROUPS-1:0] m;
    n = (filled_bits + grp_bits - 1) / grp_bits;
    m = '0;
    for (int i = 0; i < MAX_GROUPS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_packer_if.sv
// stream_packer_if
//   Upstream beat stream (up_*) and downstream packed word (dn_*).
//   slave  : packer side (consumes beats, produces words)
//   master : environment side
//   up_last exists only when STREAM_PACK_FLUSH_EN is defined.
interface stream_packer_if #(
  parameter int BAND_WIDTH = 256,
  parameter int OUT_W      = 1024,
  parameter int GROUPS     = 8
);
  logic [BAND_WIDTH-1:0] up_dat;
  logic                  up_vld;
  logic                  up_rdy;
`ifdef STREAM_PACK_FLUSH_EN
  logic                  up_last;
`endif
  logic [OUT_W-1:0]      dn_dat;
  logic [GROUPS-1:0]     dn_vld;
  logic                  dn_rdy;

  modport slave (
    input  up_dat, up_vld, dn_rdy,
`ifdef STREAM_PACK_FLUSH_EN
    input  up_last,
`endif
    output up_rdy, dn_dat, dn_vld
  );

  modport master (
    output up_dat, up_vld, dn_rdy,
`ifdef STREAM_PACK_FLUSH_EN
    output up_last,
`endif
    input  up_rdy, dn_dat, dn_vld
  );
endinterface

// File: rtl/stream_pack_out_reg.sv
// stream_pack_out_reg
//   Output holding register. A load replaces the word and its group mask; a
//   word with any valid bit set stays put until dn_rdy_i takes it. Load and
//   drain may coincide (old word leaves, new word enters).
//   Ports: clk, rst_n, load_i, load_dat_i, load_vld_i, dn_rdy_i,
//          dn_dat_o, dn_vld_o.
module stream_pack_out_reg #(
  parameter int OUT_W  = 1024,
  parameter int GROUPS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [OUT_W-1:0]  load_dat_i,
  input  logic [GROUPS-1:0] load_vld_i,
  input  logic              dn_rdy_i,
  output logic [OUT_W-1:0]  dn_dat_o,
  output logic [GROUPS-1:0] dn_vld_o
);
  logic [OUT_W-1:0]  dat_q, dat_d;
  logic [GROUPS-1:0] vld_q, vld_d;

  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (load_i) begin
      dat_d = load_dat_i;
      vld_d = load_vld_i;
    end else if (|vld_q && dn_rdy_i) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_q <= '0;
      vld_q <= '0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign dn_dat_o = dat_q;
  assign dn_vld_o = vld_q;
endmodule

// File: rtl/stream_packer.sv
// stream_packer
//   Width-up packer: gathers NUM_BEATS BAND_WIDTH-bit beats (first beat in
//   the lowest slice) into one OUT_W-bit word with per-group valids, honouring
//   downstream backpressure. Only the completing beat can be stalled.
//   Ports: clk, rst_n, bus (stream_packer_if.slave), busy.
//   Option: STREAM_PACK_FLUSH_EN adds up_last to close a partial pack early;
//   unfilled slices are zero and only touched groups are flagged valid.
module stream_packer
  import stream_pack_pkg::*;
#(
  parameter int BAND_WIDTH              = 256,
  parameter int DATA_WIDTH              = 16,
  parameter int BE_PARALLELISM          = 32,
  parameter int PARALLELISM_PER_CONTROL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_packer_if.slave  bus,
  output logic            busy
);
  localparam int OUT_W     = 2 * DATA_WIDTH * BE_PARALLELISM;
  localparam int NUM_BEATS = num_beats(BAND_WIDTH, DATA_WIDTH, BE_PARALLELISM);
  localparam int GROUPS    = groups(BE_PARALLELISM, PARALLELISM_PER_CONTROL);
  localparam int GRP_W     = grp_w(DATA_WIDTH, PARALLELISM_PER_CONTROL);
  localparam int CNT_W     = cnt_w(NUM_BEATS);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  asm_q, asm_d, word;
  logic [GROUPS-1:0] load_vld, dn_vld;
  logic [OUT_W-1:0]  dn_dat;
  logic              completing, stall, up_rdy, accept, load;

`ifdef STREAM_PACK_FLUSH_EN
  assign completing = (cnt_q == CNT_W'(NUM_BEATS - 1)) || bus.up_last;
  // For a full pack the mask covers every group, so one expression serves both.
  assign load_vld   = GROUPS'(partial_mask((int'(cnt_q) + 1) * BAND_WIDTH, GRP_W));
`else
  assign completing = (cnt_q == CNT_W'(NUM_BEATS - 1));
  assign load_vld   = '1;
`endif

  assign stall  = |dn_vld && !bus.dn_rdy;
  assign up_rdy = !(completing && stall);
  assign accept = bus.up_vld && up_rdy;
  assign load   = accept && completing;

  // Assembled word with the current beat merged into its slice; slices above
  // cnt are still zero because asm_q is cleared on every completion.
  always_comb begin
    word = asm_q;
    word[BAND_WIDTH*int'(cnt_q) +: BAND_WIDTH] = bus.up_dat;
  end

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (accept) begin
      if (completing) begin
        cnt_d = '0;
        asm_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        asm_d = word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

  stream_pack_out_reg #(
    .OUT_W  (OUT_W),
    .GROUPS (GROUPS)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .load_dat_i (word),
    .load_vld_i (load_vld),
    .dn_rdy_i   (bus.dn_rdy),
    .dn_dat_o   (dn_dat),
    .dn_vld_o   (dn_vld)
  );

  assign bus.up_rdy = up_rdy;
  assign bus.dn_dat = dn_dat;
  assign bus.dn_vld = dn_vld;
  assign busy       = (cnt_q != '0) || |dn_vld;
endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer
//   Directed bench for stream_packer at default parameters. Build with
//   STREAM_PACK_FLUSH_EN defined to also cover the early-flush path.
module tb_stream_packer;
  localparam int BW     = 256;
  localparam int OUT_W  = 1024;
  localparam int GROUPS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  stream_packer_if #(.BAND_WIDTH(BW), .OUT_W(OUT_W), .GROUPS(GROUPS)) bus ();

  stream_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        vld;
    logic        rdy;
    logic [31:0] val;
    logic        exp_urdy;
    logic [7:0]  exp_vld;
    logic        exp_busy;
    logic [31:0] w0, w1, w2, w3;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [OUT_W-1:0] mk(logic [31:0] b0, b1, b2, b3);
    return {BW'(b3), BW'(b2), BW'(b1), BW'(b0)};
  endfunction

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, rdy, input logic [31:0] val, input logic urdy,
                     input logic [7:0] ev, input logic eb,
                     input logic [31:0] w0, w1, w2, w3);
    vec_t v;
    v.vld = vld; v.rdy = rdy; v.val = val; v.exp_urdy = urdy;
    v.exp_vld = ev; v.exp_busy = eb;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
    tbl.push_back(v);
  endtask

  // One cycle: drive at negedge, check up_rdy before the edge, check
  // registered outputs 1 ns after it.
  task automatic step(input string tag, input logic vld, rdy, last,
                      input logic [BW-1:0] dat, input logic exp_urdy,
                      input logic [7:0] exp_vld, input logic exp_busy,
                      input logic [OUT_W-1:0] exp_dat);
    @(negedge clk);
    bus.up_vld = vld;
    bus.dn_rdy = rdy;
    bus.up_dat = dat;
`ifdef STREAM_PACK_FLUSH_EN
    bus.up_last = last;
`else
    if (last) $display("note: up_last ignored in this build (%s)", tag);
`endif
    #1;
    chk({tag, ".up_rdy"}, OUT_W'(bus.up_rdy), OUT_W'(exp_urdy));
    @(posedge clk);
    #1;
    chk({tag, ".dn_vld"}, OUT_W'(bus.dn_vld), OUT_W'(exp_vld));
    chk({tag, ".busy"}, OUT_W'(busy), OUT_W'(exp_busy));
    if (exp_vld != 8'h00) chk({tag, ".dn_dat"}, bus.dn_dat, exp_dat);
  endtask

  initial begin
    bus.up_vld = 1'b0;
    bus.dn_rdy = 1'b1;
    bus.up_dat = '0;
`ifdef STREAM_PACK_FLUSH_EN
    bus.up_last = 1'b0;
`endif

    // A: 12 back-to-back beats, dn_rdy=1 -> words after beats 4, 8, 12.
    for (int i = 1; i <= 12; i++) begin
      if (i % 4 == 0)
        add(1, 1, i, 1, 8'hFF, 1, i-3, i-2, i-1, i);
      else
        add(1, 1, i, 1, 8'h00, 1, 0, 0, 0, 0);
    end
    add(0, 1, 0, 1, 8'h00, 0, 0, 0, 0, 0);
    // B: backpressure; completing beat 34 stalls until dn_rdy rises.
    add(1, 0, 21, 1, 8'h00, 1, 0, 0, 0, 0);
    add(1, 0, 22, 1, 8'h00, 1, 0, 0, 0, 0);
    add(1, 0, 23, 1, 8'h00, 1, 0, 0, 0, 0);
    add(1, 0, 24, 1, 8'hFF, 1, 21, 22, 23, 24);
    add(1, 0, 31, 1, 8'hFF, 1, 21, 22, 23, 24);
    add(0, 0, 0,  1, 8'hFF, 1, 21, 22, 23, 24);
    add(1, 0, 32, 1, 8'hFF, 1, 21, 22, 23, 24);
    add(1, 0, 33, 1, 8'hFF, 1, 21, 22, 23, 24);
    add(1, 0, 34, 0, 8'hFF, 1, 21, 22, 23, 24);
    add(1, 0, 34, 0, 8'hFF, 1, 21, 22, 23, 24);
    add(1, 1, 34, 1, 8'hFF, 1, 31, 32, 33, 34);
    add(0, 1, 0,  1, 8'h00, 0, 0, 0, 0, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.dn_vld", OUT_W'(bus.dn_vld), '0);
    chk("rst.dn_dat", bus.dn_dat, '0);
    chk("rst.busy", OUT_W'(busy), '0);
    chk("rst.up_rdy", OUT_W'(bus.up_rdy), OUT_W'(1));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].vld, tbl[i].rdy, 1'b0, BW'(tbl[i].val),
           tbl[i].exp_urdy, tbl[i].exp_vld, tbl[i].exp_busy,
           mk(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3));
    end

    // Reset mid-pack: partial beats are discarded.
    step("mid.b1", 1, 1, 0, BW'(32'hAA), 1, 8'h00, 1, '0);
    step("mid.b2", 1, 1, 0, BW'(32'hBB), 1, 8'h00, 1, '0);
    @(negedge clk);
    bus.up_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst.dn_vld", OUT_W'(bus.dn_vld), '0);
    chk("midrst.dn_dat", bus.dn_dat, '0);
    chk("midrst.busy", OUT_W'(busy), '0);
    chk("midrst.up_rdy", OUT_W'(bus.up_rdy), OUT_W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    step("post.b1", 1, 1, 0, BW'(41), 1, 8'h00, 1, '0);
    step("post.b2", 1, 1, 0, BW'(42), 1, 8'h00, 1, '0);
    step("post.b3", 1, 1, 0, BW'(43), 1, 8'h00, 1, '0);
    step("post.b4", 1, 1, 0, BW'(44), 1, 8'hFF, 1, mk(41, 42, 43, 44));
    step("post.idle", 0, 1, 0, '0, 1, 8'h00, 0, '0);

`ifdef STREAM_PACK_FLUSH_EN
    // Single all-ones beat flushed -> groups 0,1 valid, upper slices zero.
    step("fl1", 1, 1, 1, '1, 1, 8'h03, 1, {{(OUT_W-BW){1'b0}}, {BW{1'b1}}});
    // Counter must be back at 0: next beat lands in the lowest slice.
    step("fl3.b1", 1, 1, 0, BW'(51), 1, 8'h00, 1, '0);
    step("fl3.b2", 1, 1, 0, BW'(52), 1, 8'h00, 1, '0);
    step("fl3.b3", 1, 1, 1, BW'(53), 1, 8'h3F, 1, mk(51, 52, 53, 0));
    step("fl3.idle", 0, 1, 0, '0, 1, 8'h00, 0, '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
